sub_4_bit_serial: RTL and testbench
===================================

SUB_4_BIT_SERIAL -- requirements
Module: sub_4_bit_serial

Interface
REQ-001 Parameter: WIDTH, 4, operand and result width in bits; legal range 2..16.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  request to begin one subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; sampled on the accepted start edge.
REQ-006 b  input  WIDTH  subtrahend; sampled on the accepted start edge.
REQ-007 bin  input  1  borrow-in; sampled on the accepted start edge.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  single-cycle pulse marking the result as complete.
REQ-010 d  output  WIDTH  difference; registered.
REQ-011 bout  output  1  borrow-out; registered.

Function
REQ-012 Computation: d SHALL equal (a - b - bin) mod 2^WIDTH.
REQ-013 Borrow: bout SHALL be 1 iff a < b + bin, with unsigned compare.
REQ-014 FSM states: IDLE and RUN only.
REQ-015 IDLE: start=1 at an edge (edge 0) SHALL latch a, b and bin, clear the bit counter, and enter RUN; busy SHALL be 1 from edge 0 onward.
REQ-016 RUN: one bit per edge, LSB first.
- Bit i SHALL be processed at edge i+1.
- di = ai ^ bi ^ br.
- br_next = (~ai & bi) | (~(ai ^ bi) & br).
- br SHALL be initialised to bin.
- Operand registers SHALL shift right; d SHALL fill from the MSB.
REQ-017 At edge WIDTH:
- the FSM SHALL return to IDLE;
- busy SHALL drop to 0;
- done SHALL rise for exactly one cycle;
- d and bout SHALL be final.
Total latency: WIDTH edges from the start edge to done.
REQ-018 d and bout SHALL hold their last result until the next accepted start, and SHALL stay unchanged while RUN is in progress.
REQ-019 start asserted during RUN SHALL be ignored and SHALL NOT affect operands or the counter.
REQ-020 start=1 in the cycle in which done=1 (FSM already in IDLE) SHALL be accepted. Back-to-back throughput SHALL be one result per WIDTH+1 cycles when start is held high.
REQ-021 Changes on a, b or bin after the start edge SHALL NOT affect the result.
REQ-022 The counter SHALL be ceil(log2(WIDTH+1)) bits wide. RUN SHALL never exceed WIDTH cycles.

Reset
REQ-023 When rst=1 at an edge, the block SHALL:
- go to IDLE;
- drive busy=0, done=0, bout=0 and d=0;
- clear the counter and the internal borrow.
REQ-024 Reset SHALL take priority over start. Reset during RUN SHALL abort the operation with no done pulse.
REQ-025 Reset SHALL NOT be asynchronous; rst rising between edges SHALL have no effect until the next edge.

Structure
REQ-026 The FSM state encodings (IDLE=0, RUN=1) and the default WIDTH constant SHALL reside in the shared arithmetic package, for reuse by the serial adder.
REQ-027 The per-bit borrow logic SHALL be one combinational sub-module, sub_1_bit, with ports a, b, bin, d and bout. It SHALL be instantiated once and time-multiplexed across bits.
REQ-028 The datapath SHALL contain no combinational path from the inputs to any output.

Verification
REQ-029 WIDTH=4, a=9, b=3, bin=0, start at edge 0 -> busy=1 over edges 0..3, done=1 after edge 4, d=6, bout=0.
REQ-030 a=3, b=9, bin=0 -> d=4'hA, bout=1; a=0, b=0, bin=1 -> d=4'hF, bout=1.
REQ-031 a=15, b=15, bin=0 with start held high for 12 cycles -> mid-operation starts ignored. Results d=0, bout=0 with done pulses after edges 4, 9 and 14 (restart accepted in each done cycle).
REQ-032 Start a=12, b=5; assert rst at edge 2 -> after edge 2: busy=0, done=0, d=0, bout=0, and no done pulse follows. A new op a=7, b=2 then yields d=5, bout=0.
REQ-033 Change a and b on the cycle after start -> result matches the latched operands.
REQ-034 Exhaustive: all 512 (a, b, bin) combinations against a behavioural model -> d and bout match, with exactly one done pulse per op.

Source files
------------

// File: rtl/sub_4_bit_serial_pkg.sv
// Shared serial-arithmetic definitions: FSM encoding and default operand width,
// common to the serial subtractor and the serial adder.
package sub_4_bit_serial_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sub_4_bit_serial_if.sv
// Operand/result bundle for the bit-serial subtractor.
interface sub_4_bit_serial_if
  import sub_4_bit_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  modport master (output start, a, b, bin, input  busy, done, d, bout);
  modport slave  (input  start, a, b, bin, output busy, done, d, bout);
endinterface

// File: rtl/sub_4_bit_serial_sub_1_bit.sv
// One-bit full subtractor; the serial datapath reuses a single copy for every bit.
module sub_1_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/sub_4_bit_serial.sv
// Bit-serial subtractor: latches operands on start, resolves one bit per clock
// LSB first, and publishes d/bout together with a one-cycle done pulse.
module sub_4_bit_serial
  import sub_4_bit_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic              clk,
  input logic              rst,
  sub_4_bit_serial_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] opa, opb, dsh;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             di, bo;

  sub_1_bit u_bit (
    .a    (opa[0]),
    .b    (opb[0]),
    .bin  (br),
    .d    (di),
    .bout (bo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      opa      <= '0;
      opb      <= '0;
      dsh      <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.d    <= '0;
      bus.bout <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= RUN;
            opa      <= bus.a;
            opb      <= bus.b;
            br       <= bus.bin;
            cnt      <= '0;
            bus.busy <= 1'b1;
          end
        end
        RUN: begin
          // Partial difference accumulates privately so d keeps the old result.
          opa <= opa >> 1;
          opb <= opb >> 1;
          br  <= bo;
          dsh <= {di, dsh[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.d    <= {di, dsh[WIDTH-1:1]};
            bus.bout <= bo;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sub_4_bit_serial.sv
// Self-checking bench for sub_4_bit_serial against an arithmetic reference model.
module tb_sub_4_bit_serial;
  import sub_4_bit_serial_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  sub_4_bit_serial_if #(.WIDTH(W)) bus ();

  sub_4_bit_serial #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: plain integer arithmetic on the whole words.
  function automatic void model(input int ia, input int ib, input int ibin,
                                output logic [W-1:0] ed, output logic ebo);
    int r;
    r   = ia - ib - ibin;
    ed  = W'(r & ((1 << W) - 1));
    ebo = (ia < ib + ibin);
  endfunction

  // Runs one operation and reports what was observed; checks happen in callers.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                       input bit scramble,
                       output logic [W-1:0] od, output logic obo, output int lat,
                       output int npulse, output bit busy_ok, output bit hold_ok);
    logic [W-1:0] d0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ia;
    bus.b     = ib;
    bus.bin   = ibin;
    d0        = bus.d;
    lat = -1; npulse = 0; busy_ok = 1'b1; hold_ok = 1'b1; od = 'x; obo = 1'bx;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (scramble) begin
      bus.a   = W'($urandom);
      bus.b   = W'($urandom);
      bus.bin = 1'($urandom);
    end
    if (bus.busy !== 1'b1) busy_ok = 1'b0;
    if (bus.d !== d0) hold_ok = 1'b0;
    for (int k = 1; k <= W + 3; k++) begin
      @(posedge clk); #1;
      if (k < W) begin
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
        if (bus.d !== d0) hold_ok = 1'b0;
      end else if (bus.busy !== 1'b0) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin
        npulse++;
        if (lat < 0) begin
          lat = k; od = bus.d; obo = bus.bout;
        end
      end
      if (k == W + 3 && lat > 0 && (bus.d !== od || bus.bout !== obo)) hold_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.a = 4'd9; bus.b = 4'd3; bus.bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.bout, bus.d} !== 7'd0)
      $display("FAIL reset_outputs: got busy=%b done=%b bout=%b d=%h, expected all 0",
               bus.busy, bus.done, bus.bout, bus.d);
    else n_pass++;
    @(negedge clk);
    bus.start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL reset_idle: busy=%b expected 0", bus.busy);
    else n_pass++;
  endtask

  task automatic test_vectors();
    logic [W-1:0] va[3] = '{4'd9, 4'd3, 4'd0};
    logic [W-1:0] vb[3] = '{4'd3, 4'd9, 4'd0};
    logic         vc[3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] xd[3] = '{4'h6, 4'hA, 4'hF};
    logic         xb[3] = '{1'b0, 1'b1, 1'b1};
    logic [W-1:0] od; logic obo; int lat, np; bit bok, hok;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], vc[i], 1'b0, od, obo, lat, np, bok, hok);
      n_checks++;
      if (od !== xd[i] || obo !== xb[i])
        $display("FAIL vector%0d_result: got d=%h bout=%b expected d=%h bout=%b",
                 i, od, obo, xd[i], xb[i]);
      else n_pass++;
      n_checks++;
      if (lat !== W || np !== 1 || !bok || !hok)
        $display("FAIL vector%0d_timing: got lat=%0d pulses=%0d busy_ok=%0d hold_ok=%0d expected %0d 1 1 1",
                 i, lat, np, bok, hok, W);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int seen[$];
    int exp_e[3] = '{4, 9, 14};
    bit bad;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd15; bus.b = 4'd15; bus.bin = 1'b0;
    for (int e = 0; e < 17; e++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        seen.push_back(e);
        n_checks++;
        if (bus.d !== 4'd0 || bus.bout !== 1'b0)
          $display("FAIL b2b_result_e%0d: got d=%h bout=%b expected d=0 bout=0", e, bus.d, bus.bout);
        else n_pass++;
      end
      if (e == 11) bus.start = 1'b0;
    end
    bad = (seen.size() != 3);
    for (int i = 0; i < 3 && !bad; i++) if (seen[i] != exp_e[i]) bad = 1'b1;
    n_checks++;
    if (bad) $display("FAIL b2b_done_edges: got %0d pulses, expected pulses at edges 4 9 14", seen.size());
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] od; logic obo; int lat, np; bit bok, hok, extra;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd12; bus.b = 4'd5; bus.bin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.bout, bus.d} !== 7'd0)
      $display("FAIL abort_outputs: got busy=%b done=%b bout=%b d=%h expected all 0",
               bus.busy, bus.done, bus.bout, bus.d);
    else n_pass++;
    rst = 1'b0;
    extra = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra = 1'b1;
    end
    n_checks++;
    if (extra) $display("FAIL abort_no_done: activity after reset, expected none");
    else n_pass++;
    do_op(4'd7, 4'd2, 1'b0, 1'b0, od, obo, lat, np, bok, hok);
    n_checks++;
    if (od !== 4'd5 || obo !== 1'b0 || lat !== W || np !== 1)
      $display("FAIL abort_followup: got d=%h bout=%b lat=%0d pulses=%0d expected d=5 bout=0 lat=%0d pulses=1",
               od, obo, lat, np, W);
    else n_pass++;
  endtask

  task automatic test_operand_change();
    logic [W-1:0] od, ed; logic obo, ebo; int lat, np; bit bok, hok;
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb; logic rc;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      model(int'(ra), int'(rb), int'(rc), ed, ebo);
      do_op(ra, rb, rc, 1'b1, od, obo, lat, np, bok, hok);
      n_checks++;
      if (od !== ed || obo !== ebo || lat !== W || np !== 1)
        $display("FAIL latch_%0d: a=%h b=%h bin=%b got d=%h bout=%b lat=%0d expected d=%h bout=%b lat=%0d",
                 i, ra, rb, rc, od, obo, lat, ed, ebo, W);
      else n_pass++;
    end
  endtask

  task automatic test_exhaustive();
    logic [W-1:0] od, ed; logic obo, ebo; int lat, np; bit bok, hok;
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          model(ia, ib, ic, ed, ebo);
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
          do_op(W'(ia), W'(ib), 1'(ic), 1'($urandom), od, obo, lat, np, bok, hok);
          n_checks++;
          if (od !== ed || obo !== ebo)
            $display("FAIL exh_result a=%h b=%h bin=%0d: got d=%h bout=%b expected d=%h bout=%b",
                     ia, ib, ic, od, obo, ed, ebo);
          else n_pass++;
          n_checks++;
          if (lat !== W || np !== 1 || !bok || !hok)
            $display("FAIL exh_timing a=%h b=%h bin=%0d: got lat=%0d pulses=%0d busy_ok=%0d hold_ok=%0d expected %0d 1 1 1",
                     ia, ib, ic, lat, np, bok, hok, W);
          else n_pass++;
        end
  endtask

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_abort();
    test_operand_change();
    test_exhaustive();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
